readout_vote_accum: RTL and testbench

Streaming accumulator placed directly downstream of the final LogicNets layer. Each beat carries one shot's per-qubit state decisions: one bit per final-layer neuron, the 1-bit outputs of the layer-2 neuron LUTs concatenated. The block counts ones per qubit over a fixed batch of SHOTS shots, then presents per-qubit counts and a majority decision through a valid/ready handshake to the readout interface.

---
 rtl/readout_vote_accum.sv | 130 +++++++++++++
 tb/tb_readout_vote_accum.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/readout_vote_accum.sv
// readout_vote_accum
//
// Streaming per-qubit vote accumulator. It sits directly after the final
// LogicNets layer. Each accepted beat carries one shot: one decision bit per
// qubit. Over a batch of SHOTS shots the block counts the ones for each qubit.
// It then presents the counts and a strict-majority decision per qubit on a
// valid/ready output.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (overrides everything)
//   start         one-cycle pulse that opens a batch; honoured only in IDLE
//   in_valid      in_bits holds a shot
//   in_ready      shot accepted this cycle when in_valid is also high (ACCUM)
//   in_bits       NQ decision bits, bit q belongs to qubit q
//   out_valid     batch result available (DONE)
//   out_ready     consumer takes the result
//   out_counts    per-qubit counts, qubit q in bits [q*CW +: CW]
//   out_majority  bit q set when 2*count_q > SHOTS (a tie gives 0)
//   busy          high while a batch is open or its result is pending
module readout_vote_accum #(
  parameter int NQ    = 5,
  parameter int SHOTS = 16,
  parameter int CW    = $clog2(SHOTS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NQ-1:0]   in_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NQ*CW-1:0] out_counts,
  output logic [NQ-1:0]   out_majority,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Majority threshold is compared one bit wider than the counts, so that
  // 2*count never wraps.
  localparam logic [CW:0]   SHOTS_W  = (CW + 1)'(SHOTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(SHOTS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   shot_cnt;
  logic [CW-1:0]   cnt     [NQ];
  logic [CW-1:0]   cnt_nxt [NQ];
  logic [NQ-1:0]   maj_nxt;
  logic [NQ-1:0]   maj_r;
  logic            accept;
  logic            last_shot;
  logic            clear;

  // Handshake qualifiers. in_ready depends only on state, so accept has no
  // combinational path back to in_valid.
  assign accept    = in_valid && in_ready;
  assign last_shot = accept && (shot_cnt == LAST_IDX);
  assign clear     = (state == IDLE) && start;

  // Next-state and handshake outputs. A start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_shot) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counts as they would be after accepting the current beat. The majority
  // computed from these is the value latched on the final shot of the batch.
  always_comb begin
    maj_nxt = '0;
    for (int q = 0; q < NQ; q++) begin
      cnt_nxt[q] = cnt[q] + CW'(in_bits[q]);
      maj_nxt[q] = {cnt_nxt[q], 1'b0} > SHOTS_W;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counters and the majority register. They are cleared only by reset or by
  // a start that opens a new batch. After DONE they keep the last result
  // through IDLE.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shot_cnt <= '0;
      maj_r    <= '0;
      for (int q = 0; q < NQ; q++) cnt[q] <= '0;
    end else if (accept) begin
      shot_cnt <= shot_cnt + CW'(1);
      for (int q = 0; q < NQ; q++) cnt[q] <= cnt_nxt[q];
      if (last_shot) maj_r <= maj_nxt;
    end
  end

  // Flatten the per-qubit counts onto the output bus.
  always_comb begin
    out_counts = '0;
    for (int q = 0; q < NQ; q++) out_counts[q*CW +: CW] = cnt[q];
  end

  assign out_majority = maj_r;

endmodule

// File: tb/tb_readout_vote_accum.sv
// tb_readout_vote_accum
//
// Directed bench for readout_vote_accum. The main instance uses the default
// build (NQ=5, SHOTS=16, CW=5). A second instance uses SHOTS=1.
// Expected values are hand-computed and held in a vector table. The table is
// followed by hand-written sequences for the mid-batch reset, the ignored
// start and the SHOTS=1 case.
module tb_readout_vote_accum;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [4:0]  in_bits;
  logic        in_ready, out_valid, busy;
  logic [24:0] out_counts;
  logic [4:0]  out_majority;

  logic        s1_rst, s1_start, s1_in_valid, s1_out_ready;
  logic [4:0]  s1_in_bits;
  logic        s1_in_ready, s1_out_valid, s1_busy;
  logic [4:0]  s1_out_counts;
  logic [4:0]  s1_out_majority;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [4:0]  bits;
    logic        out_ready;
    logic        e_ir;
    logic        e_ov;
    logic        e_busy;
    logic        chk;
    logic [24:0] e_cnt;
    logic [4:0]  e_maj;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  readout_vote_accum #(.NQ(5), .SHOTS(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_counts(out_counts), .out_majority(out_majority), .busy(busy)
  );

  readout_vote_accum #(.NQ(5), .SHOTS(1)) dut1 (
    .clk(clk), .rst(s1_rst), .start(s1_start),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_bits(s1_in_bits),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .out_counts(s1_out_counts), .out_majority(s1_out_majority), .busy(s1_busy)
  );

  // Pack five per-qubit counts into the 25-bit out_counts layout.
  function automatic logic [24:0] pk(input int c0, input int c1, input int c2,
                                     input int c3, input int c4);
    logic [4:0] a0, a1, a2, a3, a4;
    a0 = 5'(c0); a1 = 5'(c1); a2 = 5'(c2); a3 = 5'(c3); a4 = 5'(c4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic addVec(input logic r, input logic st, input logic iv,
                        input logic [4:0] b, input logic ordy,
                        input logic eir, input logic eov, input logic ebusy,
                        input logic chk, input logic [24:0] ec,
                        input logic [4:0] em);
    vec_t v;
    v.rst = r; v.start = st; v.in_valid = iv; v.bits = b; v.out_ready = ordy;
    v.e_ir = eir; v.e_ov = eov; v.e_busy = ebusy; v.chk = chk;
    v.e_cnt = ec; v.e_maj = em;
    tbl.push_back(v);
  endtask

  // Advance one cycle. Outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; start = v.start; in_valid = v.in_valid;
    in_bits = v.bits; out_ready = v.out_ready;
    tick();
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic eir,
                             input logic eov, input logic ebusy, input logic chk,
                             input logic [24:0] ec, input logic [4:0] em);
    check1({tag, ".in_ready"}, idx, 32'(in_ready), 32'(eir));
    check1({tag, ".out_valid"}, idx, 32'(out_valid), 32'(eov));
    check1({tag, ".busy"}, idx, 32'(busy), 32'(ebusy));
    if (chk) begin
      check1({tag, ".out_counts"}, idx, 32'(out_counts), 32'(ec));
      check1({tag, ".out_majority"}, idx, 32'(out_majority), 32'(em));
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic iv,
                       input logic [4:0] b, input logic ordy);
    rst = r; start = st; in_valid = iv; in_bits = b; out_ready = ordy;
    tick();
  endtask

  initial begin
    int a0, a1, k;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
    s1_rst = 1'b1; s1_start = 1'b0; s1_in_valid = 1'b0; s1_in_bits = '0;
    s1_out_ready = 1'b0;

    // Reset, then IDLE ignores in_valid and out_ready, then start.
    addVec(1, 0, 0, 5'h00, 0, 0, 0, 0, 1, '0, '0);
    addVec(0, 0, 1, 5'h1f, 1, 0, 0, 0, 1, '0, '0);
    addVec(0, 1, 0, 5'h00, 0, 1, 0, 1, 1, '0, '0);

    // Basic batch: 16 shots of qubit 0 only.
    for (int i = 1; i <= 16; i++)
      addVec(0, 0, 1, 5'b00001, 0, i < 16, i == 16, 1, 1, pk(i, 0, 0, 0, 0),
             (i == 16) ? 5'b00001 : 5'b00000);

    // Back-pressure: the result holds and start or in_valid change nothing.
    for (int j = 0; j < 10; j++)
      addVec(0, j % 2, 1, 5'h1f, 0, 0, 1, 1, 1, pk(16, 0, 0, 0, 0), 5'b00001);

    // Release together with a start. The start is ignored because the
    // state is DONE. Results hold in IDLE.
    addVec(0, 1, 1, 5'h1f, 1, 0, 0, 0, 1, pk(16, 0, 0, 0, 0), 5'b00001);
    // A new start clears the counters.
    addVec(0, 1, 0, 5'h00, 0, 1, 0, 1, 1, '0, '0);

    // Tie and threshold: shots alternate 00011 / 00001, with stalls in between.
    a0 = 0; a1 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 1)
        addVec(0, 0, 0, 5'h1f, 0, 1, 0, 1, 1, pk(a0, a1, 0, 0, 0), '0);
      a0++;
      if (i % 2 == 0) a1++;
      addVec(0, 0, 1, (i % 2 == 0) ? 5'b00011 : 5'b00001, 0, i < 15, i == 15, 1,
             1, pk(a0, a1, 0, 0, 0), (i == 15) ? 5'b00001 : 5'b00000);
    end
    addVec(0, 0, 0, 5'h00, 1, 0, 0, 0, 1, pk(16, 8, 0, 0, 0), 5'b00001);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput("vec", i, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_busy, tbl[i].chk,
                  tbl[i].e_cnt, tbl[i].e_maj);
    end

    // Reset mid-batch after 7 accepted shots of all ones.
    drive(0, 1, 0, 5'h00, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 5'h1f, 0);
    checkOutput("rst_pre", 0, 1, 0, 1, 1, pk(7, 7, 7, 7, 7), '0);
    drive(1, 1, 1, 5'h1f, 1);
    checkOutput("rst_mid", 0, 0, 0, 0, 1, '0, '0);
    drive(0, 1, 0, 5'h00, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 5'h1f, 0);
    checkOutput("rst_fresh", 0, 0, 1, 1, 1, pk(16, 16, 16, 16, 16), 5'b11111);
    drive(0, 0, 0, 5'h00, 1);
    checkOutput("rst_fresh_rel", 0, 0, 0, 0, 0, '0, '0);

    // Ignored start at shot 5. Qubit 1 ties at 8 of 16, so its majority is 0.
    drive(0, 1, 0, 5'h00, 0);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, i == 4, 1, (i < 8) ? 5'b10110 : 5'b10100, 0);
      if (i == 14) checkOutput("ign_mid", 0, 1, 0, 1, 1, pk(0, 8, 15, 0, 15), '0);
    end
    checkOutput("ign_end", 0, 0, 1, 1, 1, pk(0, 8, 16, 0, 16), 5'b10100);
    drive(0, 0, 0, 5'h00, 1);

    // SHOTS=1 build.
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s1_rst = 1'b1; tick();
    s1_rst = 1'b0;
    check1("s1_reset_ov", 0, 32'(s1_out_valid), 32'd0);
    s1_start = 1'b1; tick();
    s1_start = 1'b0;
    check1("s1_start_ir", 0, 32'(s1_in_ready), 32'd1);
    s1_in_valid = 1'b1; s1_in_bits = 5'b10101; tick();
    s1_in_valid = 1'b0;
    check1("s1_ov", 0, 32'(s1_out_valid), 32'd1);
    check1("s1_ir", 0, 32'(s1_in_ready), 32'd0);
    check1("s1_counts", 0, 32'(s1_out_counts), 32'b10101);
    check1("s1_maj", 0, 32'(s1_out_majority), 32'b10101);
    s1_out_ready = 1'b1; tick();
    s1_out_ready = 1'b0;
    check1("s1_rel_ov", 0, 32'(s1_out_valid), 32'd0);
    check1("s1_rel_busy", 0, 32'(s1_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
